back_or_window: RTL and testbench

//  Parametrised back-plane region former for the MUSE PID trigger. Each of N_BACK back

---
 rtl/back_or_window.sv | 126 ++++++++++++
 tb/tb_back_or_window.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/back_or_window.sv
// Back-plane region former: per-bar rise detect, mask and pulse stretch, then an OR
// into overlapping bar windows, with registered region hits, any-flag and multiplicity.
module back_or_window #(
    parameter int N_BACK = 28,
    parameter int N_REG  = 18,
    parameter int IW     = 8,
    parameter logic [N_REG*IW-1:0] REG_LO = {
        8'd23, 8'd21, 8'd20, 8'd19, 8'd17, 8'd16, 8'd15, 8'd13, 8'd12,
        8'd11, 8'd9,  8'd8,  8'd6,  8'd5,  8'd4,  8'd2,  8'd1,  8'd0
    },
    parameter logic [N_REG*IW-1:0] REG_HI = {
        8'd27, 8'd26, 8'd25, 8'd23, 8'd22, 8'd21, 8'd19, 8'd18, 8'd16,
        8'd15, 8'd14, 8'd12, 8'd11, 8'd10, 8'd8,  8'd7,  8'd6,  8'd4
    },
    parameter int CW = 8,
    parameter int MW = $clog2(N_REG + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N_BACK-1:0] back_in,
    input  logic [N_BACK-1:0] bar_mask,
    input  logic [CW-1:0]     stretch_len,
    input  logic              latch_mode,
    input  logic              clear,
    output logic [N_REG-1:0]  region_out,
    output logic              region_any,
    output logic [MW-1:0]     region_mult
);

    function automatic bit tables_ok();
        bit ok;
        ok = 1'b1;
        for (int i = 0; i < N_REG; i++) begin
            if (int'(REG_LO[i*IW +: IW]) > int'(REG_HI[i*IW +: IW])) ok = 1'b0;
            if (int'(REG_HI[i*IW +: IW]) >= N_BACK) ok = 1'b0;
        end
        if (N_BACK > (1 << IW)) ok = 1'b0;
        return ok;
    endfunction

    localparam bit TABLES_OK = tables_ok();

    if (!TABLES_OK) begin : g_bad_tables
        $fatal(1, "back_or_window: region window table out of range");
    end

    logic [N_BACK-1:0] back_prev_q, back_prev_d;
    logic [CW-1:0]     cnt_q [N_BACK];
    logic [CW-1:0]     cnt_d [N_BACK];
    logic [N_REG-1:0]  region_out_q, region_out_d;
    logic              region_any_q, region_any_d;
    logic [MW-1:0]     region_mult_q, region_mult_d;

    logic [N_BACK-1:0] rise;
    logic [N_BACK-1:0] bar_act;
    logic [N_REG-1:0]  region_raw;
    logic [CW-1:0]     load_len;

    always_comb begin
        back_prev_d = back_in;
        rise        = back_in & ~back_prev_q & ~bar_mask;
        load_len    = (stretch_len == '0) ? CW'(1) : stretch_len;
        for (int j = 0; j < N_BACK; j++) begin
            // Mask wins over a rise so a disabled bar can never start or keep a stretch.
            cnt_d[j] = cnt_q[j];
            if (bar_mask[j]) begin
                cnt_d[j] = '0;
            end else if (rise[j]) begin
                cnt_d[j] = load_len;
            end else if (cnt_q[j] != '0) begin
                cnt_d[j] = cnt_q[j] - CW'(1);
            end
            bar_act[j] = (cnt_q[j] != '0);
        end
    end

    always_comb begin
        region_raw = '0;
        for (int i = 0; i < N_REG; i++) begin
            for (int j = 0; j < N_BACK; j++) begin
                if (j >= int'(REG_LO[i*IW +: IW]) && j <= int'(REG_HI[i*IW +: IW])) begin
                    region_raw[i] = region_raw[i] | bar_act[j];
                end
            end
        end
    end

    always_comb begin
        // A new hit ORed after the clear survives a coincident clear.
        if (latch_mode) begin
            region_out_d = (clear ? '0 : region_out_q) | region_raw;
        end else begin
            region_out_d = region_raw;
        end
        region_any_d  = |region_raw;
        region_mult_d = '0;
        for (int i = 0; i < N_REG; i++) begin
            region_mult_d = region_mult_d + MW'(region_out_q[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            back_prev_q   <= '1;
            region_out_q  <= '0;
            region_any_q  <= 1'b0;
            region_mult_q <= '0;
            for (int j = 0; j < N_BACK; j++) begin
                cnt_q[j] <= '0;
            end
        end else begin
            back_prev_q   <= back_prev_d;
            region_out_q  <= region_out_d;
            region_any_q  <= region_any_d;
            region_mult_q <= region_mult_d;
            for (int j = 0; j < N_BACK; j++) begin
                cnt_q[j] <= cnt_d[j];
            end
        end
    end

    assign region_out  = region_out_q;
    assign region_any  = region_any_q;
    assign region_mult = region_mult_q;

endmodule

// File: tb/tb_back_or_window.sv
// Bench for back_or_window: directed scenarios plus random traffic, checked every
// cycle against an event-time reference model through an expected-value queue.
module tb_back_or_window;

    localparam int N_BACK = 28;
    localparam int N_REG  = 18;
    localparam int CW     = 8;
    localparam int MW     = 5;
    localparam int W      = N_REG + 1 + MW;

    logic              clk;
    logic              rst_n;
    logic [N_BACK-1:0] back_in;
    logic [N_BACK-1:0] bar_mask;
    logic [CW-1:0]     stretch_len;
    logic              latch_mode;
    logic              clear;
    logic [N_REG-1:0]  region_out;
    logic              region_any;
    logic [MW-1:0]     region_mult;

    back_or_window dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .back_in     (back_in),
        .bar_mask    (bar_mask),
        .stretch_len (stretch_len),
        .latch_mode  (latch_mode),
        .clear       (clear),
        .region_out  (region_out),
        .region_any  (region_any),
        .region_mult (region_mult)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // reference model: each bar remembers the last edge index at which it is still active
    int reg_lo [N_REG] = '{0, 1, 2, 4, 5, 6, 8, 9, 11, 12, 13, 15, 16, 17, 19, 20, 21, 23};
    int reg_hi [N_REG] = '{4, 6, 7, 8, 10, 11, 12, 14, 15, 16, 18, 19, 21, 22, 23, 25, 26, 27};
    int               end_e [N_BACK];
    logic [N_BACK-1:0] m_prev;
    logic [N_REG-1:0] exp_out;
    logic             exp_any;
    logic [MW-1:0]    exp_mult;
    int               e;

    logic [W-1:0] exp_q[$];
    int checks;
    int errors;
    bit running;

    task automatic model_step();
        logic [N_REG-1:0] raw;
        int len;
        raw = '0;
        for (int i = 0; i < N_REG; i++)
            for (int j = reg_lo[i]; j <= reg_hi[i]; j++)
                if (e <= end_e[j]) raw[i] = 1'b1;
        if (!rst_n) begin
            exp_out  = '0;
            exp_any  = 1'b0;
            exp_mult = '0;
            m_prev   = '1;
            for (int j = 0; j < N_BACK; j++) end_e[j] = e;
        end else begin
            exp_mult = MW'($countones(exp_out));
            exp_out  = latch_mode ? ((clear ? '0 : exp_out) | raw) : raw;
            exp_any  = |raw;
            len      = (stretch_len == 0) ? 1 : int'(stretch_len);
            for (int j = 0; j < N_BACK; j++) begin
                if (bar_mask[j]) end_e[j] = e;
                else if (back_in[j] && !m_prev[j]) end_e[j] = e + len;
            end
            m_prev = back_in;
        end
        exp_q.push_back({exp_out, exp_any, exp_mult});
        e++;
    endtask

    // driver tasks
    task automatic tick();
        running = 1'b1;
        model_step();
        @(posedge clk);
        #2;
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    // scoreboard monitor
    always @(posedge clk) begin
        logic [W-1:0] w;
        #1;
        if (running) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL queue_empty at %0t: DUT output with no expectation", $time);
            end else begin
                w = exp_q.pop_front();
                checks++;
                if (region_out !== w[W-1 -: N_REG]) begin
                    errors++;
                    $display("FAIL region_out at %0t: got %h expected %h", $time, region_out, w[W-1 -: N_REG]);
                end
                checks++;
                if (region_any !== w[MW]) begin
                    errors++;
                    $display("FAIL region_any at %0t: got %b expected %b", $time, region_any, w[MW]);
                end
                checks++;
                if (region_mult !== w[MW-1:0]) begin
                    errors++;
                    $display("FAIL region_mult at %0t: got %0d expected %0d", $time, region_mult, w[MW-1:0]);
                end
            end
        end
    end

    initial begin
        checks  = 0;
        errors  = 0;
        running = 1'b0;
        e       = 0;
        exp_out = '0;
        exp_any = 1'b0;
        exp_mult = '0;
        m_prev  = '1;
        for (int j = 0; j < N_BACK; j++) end_e[j] = -1;

        rst_n = 1'b0; back_in = '0; bar_mask = '0; stretch_len = 8'd4;
        latch_mode = 1'b0; clear = 1'b0;

        // reset with bar 5 already high: no pulse after release
        back_in[5] = 1'b1;
        ticks(3);
        rst_n = 1'b1;
        ticks(6);
        back_in = '0;
        ticks(3);

        // single rise on bar 3, stretch 4
        back_in[3] = 1'b1;
        ticks(3);
        back_in[3] = 1'b0;
        ticks(6);

        // bar 10 held high for 50 cycles, stretch 5
        stretch_len = 8'd5;
        back_in[10] = 1'b1;
        ticks(50);
        back_in[10] = 1'b0;
        ticks(3);

        // retrigger on bar 0
        stretch_len = 8'd4;
        back_in[0] = 1'b1; tick();
        back_in[0] = 1'b0; ticks(2);
        back_in[0] = 1'b1; tick();
        back_in[0] = 1'b0; ticks(8);

        // mask bar 27 two cycles into its stretch, then a masked rise
        stretch_len = 8'd6;
        back_in[27] = 1'b1; ticks(2);
        bar_mask[27] = 1'b1; ticks(3);
        back_in[27] = 1'b0; tick();
        back_in[27] = 1'b1; ticks(3);
        bar_mask[27] = 1'b0; ticks(3);
        back_in[27] = 1'b0; ticks(2);

        // latch mode: hold, clear alone, clear with a coincident bar 24 hit
        latch_mode = 1'b1;
        stretch_len = 8'd3;
        back_in[27] = 1'b1; tick();
        back_in[27] = 1'b0; ticks(8);
        pulse_clear();
        ticks(3);
        back_in[24] = 1'b1; tick();
        pulse_clear();
        back_in[24] = 1'b0; ticks(8);
        pulse_clear();
        back_in[15] = 1'b1; pulse_clear();
        back_in[15] = 1'b0; ticks(5);
        latch_mode = 1'b0; ticks(4);

        // reset mid-stretch
        stretch_len = 8'd8;
        back_in[5] = 1'b1; ticks(3);
        rst_n = 1'b0; tick();
        rst_n = 1'b1; back_in[5] = 1'b0; ticks(4);

        // stretch_len 0 gives one-cycle pulses; stretch_len change mid-stretch
        stretch_len = 8'd0;
        for (int k = 0; k < 3; k++) begin
            back_in[7] = 1'b1; tick();
            back_in[7] = 1'b0; ticks(2);
        end
        stretch_len = 8'd6;
        back_in[12] = 1'b1; tick();
        stretch_len = 8'd1; ticks(3);
        back_in[20] = 1'b1; ticks(8);
        back_in = '0; ticks(3);

        // random traffic
        for (int k = 0; k < 800; k++) begin
            for (int j = 0; j < N_BACK; j++)
                if ($urandom_range(0, 7) == 0) back_in[j] = ~back_in[j];
            if ($urandom_range(0, 19) == 0) bar_mask = N_BACK'($urandom()) & N_BACK'($urandom());
            if ($urandom_range(0, 29) == 0) bar_mask = '0;
            if ($urandom_range(0, 9) == 0) stretch_len = 8'($urandom_range(0, 7));
            if ($urandom_range(0, 39) == 0) latch_mode = ~latch_mode;
            clear = ($urandom_range(0, 9) == 0);
            rst_n = ($urandom_range(0, 99) != 0);
            tick();
        end
        rst_n = 1'b1; clear = 1'b0; back_in = '0; bar_mask = '0;
        ticks(10);

        running = 1'b0;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL queue_leftover: %0d entries remain, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
